// File: rtl/sa_seq_ctrl_if.sv
// rtl/sa_seq_ctrl_if.sv - control/memory bus bundle for the systolic-array sequencer
// Carries the start/done handshake, instruction fetch, operand read strobes,
// PE control and output-memory write signals.
//   master : sequencer side (drives everything except ap_start and instr_data)
//   slave  : host / memory side
interface sa_seq_ctrl_if #(
  parameter int IADDR_W = 3,
  parameter int COL_W   = 8,
  parameter int OADDR_W = 7
);
  logic               ap_start;
  logic               ap_done;
  logic               busy;
  logic [IADDR_W-1:0] instr_addr;
  logic [3:0]         instr_data;
  logic [3:0]         cur_instr;
  logic               rd_en;
  logic [COL_W-1:0]   rd_col;
  logic               feed_valid;
  logic               acc_clr;
  logic [3:0]         res_sel;
  logic               out_we;
  logic [OADDR_W-1:0] out_addr;
  logic               ovf;
  logic [31:0]        perf_cycles;

  modport master (
    input  ap_start, instr_data,
    output ap_done, busy, instr_addr, cur_instr, rd_en, rd_col, feed_valid,
           acc_clr, res_sel, out_we, out_addr, ovf, perf_cycles
  );

  modport slave (
    output ap_start, instr_data,
    input  ap_done, busy, instr_addr, cur_instr, rd_en, rd_col, feed_valid,
           acc_clr, res_sel, out_we, out_addr, ovf, perf_cycles
  );
endinterface

// File: rtl/sa_seq_ctrl.sv
// rtl/sa_seq_ctrl.sv - instruction-driven tile-job sequencer for the 4x4 systolic array
// Fetches 4-bit opcodes K from an 8-entry instruction memory; each K != 0 runs one
// job: clear accumulators, stream K+ROWS-1 skewed columns, drain, write 16 results.
// Opcode 0 or the 8th executed job ends the program (ap_done).
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - sa_seq_ctrl_if.master: ap_start/ap_done/busy handshake, instr_addr/instr_data
//          fetch, cur_instr, rd_en/rd_col/feed_valid operand read, acc_clr, res_sel,
//          out_we/out_addr result write, sticky ovf, perf_cycles
// Optional feature macro: SA_SEQ_PERF_EN builds the perf_cycles run counter;
// without it perf_cycles is tied to 0.
module sa_seq_ctrl #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int IADDR_W   = 3,
  parameter int COL_W     = 8,
  parameter int OADDR_W   = 7,
  parameter int DRAIN_CYC = 7
) (
  input  logic          clk,
  input  logic          rst,
  sa_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, CLEAR, FEED, DRAIN, WRITE, DONE
  } state_t;

  localparam int BANK     = 1 << COL_W;
  localparam int OMAX     = (1 << OADDR_W) - 1;
  localparam int RES_LAST = ROWS * COLS - 1;

  state_t             state;
  logic [IADDR_W-1:0] pc;
  logic [COL_W:0]     base;
  logic [OADDR_W:0]   oaddr;   // one extra bit so "past the end" is representable
  logic [4:0]         cnt;

  logic               ap_done_q;
  logic               busy_q;
  logic [IADDR_W-1:0] instr_addr_q;
  logic [3:0]         cur_instr_q;
  logic               rd_en_q;
  logic [COL_W-1:0]   rd_col_q;
  logic               feed_valid_q;
  logic               acc_clr_q;
  logic [3:0]         res_sel_q;
  logic               out_we_q;
  logic [OADDR_W-1:0] out_addr_q;
  logic               ovf_q;

  logic [COL_W:0]     job_span;     // K + ROWS - 1 columns consumed by the job
  logic [COL_W+1:0]   job_end_col;
  logic               col_ovf;
  logic [4:0]         feed_last;
  logic [IADDR_W-1:0] pc_next;
  logic               wr_ok;

  assign job_span    = (COL_W+1)'(cur_instr_q) + (COL_W+1)'(ROWS - 1);
  assign job_end_col = {1'b0, base} + {1'b0, job_span};
  assign col_ovf     = job_end_col > (COL_W+2)'(BANK);
  assign feed_last   = 5'(cur_instr_q) + 5'(ROWS - 2);
  assign pc_next     = pc + IADDR_W'(1);
  assign wr_ok       = oaddr <= (OADDR_W+1)'(OMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= '0;
      base         <= '0;
      oaddr        <= '0;
      cnt          <= '0;
      ap_done_q    <= 1'b0;
      busy_q       <= 1'b0;
      instr_addr_q <= '0;
      cur_instr_q  <= '0;
      rd_en_q      <= 1'b0;
      rd_col_q     <= '0;
      feed_valid_q <= 1'b0;
      acc_clr_q    <= 1'b0;
      res_sel_q    <= '0;
      out_we_q     <= 1'b0;
      out_addr_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      // memory data reaches the array one cycle after the read strobe
      feed_valid_q <= rd_en_q;

      case (state)
        IDLE, DONE: begin
          if (bus.ap_start) begin
            state        <= FETCH;
            pc           <= '0;
            base         <= '0;
            oaddr        <= '0;
            ovf_q        <= 1'b0;
            ap_done_q    <= 1'b0;
            busy_q       <= 1'b1;
            instr_addr_q <= '0;
          end
        end

        FETCH: state <= DECODE;

        DECODE: begin
          cur_instr_q <= bus.instr_data;
          if (bus.instr_data == 4'd0) begin
            state     <= DONE;
            busy_q    <= 1'b0;
            ap_done_q <= 1'b1;
          end else begin
            state     <= CLEAR;
            acc_clr_q <= 1'b1;
          end
        end

        CLEAR: begin
          acc_clr_q <= 1'b0;
          if (col_ovf) begin
            // job does not fit in the bank: flag it and fall through to job end
            ovf_q <= 1'b1;
            pc    <= pc_next;
            base  <= base + job_span;
            if (pc_next == '0) begin
              state     <= DONE;
              busy_q    <= 1'b0;
              ap_done_q <= 1'b1;
            end else begin
              state        <= FETCH;
              instr_addr_q <= pc_next;
            end
          end else begin
            state    <= FEED;
            rd_en_q  <= 1'b1;
            rd_col_q <= base[COL_W-1:0];
            cnt      <= '0;
          end
        end

        FEED: begin
          if (cnt == feed_last) begin
            state   <= DRAIN;
            rd_en_q <= 1'b0;
            cnt     <= '0;
          end else begin
            cnt      <= cnt + 5'd1;
            rd_col_q <= rd_col_q + COL_W'(1);
          end
        end

        DRAIN: begin
          if (cnt == 5'(DRAIN_CYC - 1)) begin
            state     <= WRITE;
            res_sel_q <= '0;
            if (wr_ok) begin
              out_we_q   <= 1'b1;
              out_addr_q <= oaddr[OADDR_W-1:0];
              oaddr      <= oaddr + (OADDR_W+1)'(1);
            end else begin
              out_we_q <= 1'b0;
              ovf_q    <= 1'b1;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end

        WRITE: begin
          if (res_sel_q == 4'(RES_LAST)) begin
            out_we_q <= 1'b0;
            pc       <= pc_next;
            base     <= base + job_span;
            if (pc_next == '0) begin
              state     <= DONE;
              busy_q    <= 1'b0;
              ap_done_q <= 1'b1;
            end else begin
              state        <= FETCH;
              instr_addr_q <= pc_next;
            end
          end else begin
            res_sel_q <= res_sel_q + 4'd1;
            // past the end of output space: hold out_addr, drop the write
            if (wr_ok) begin
              out_we_q   <= 1'b1;
              out_addr_q <= oaddr[OADDR_W-1:0];
              oaddr      <= oaddr + (OADDR_W+1)'(1);
            end else begin
              out_we_q <= 1'b0;
              ovf_q    <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SA_SEQ_PERF_EN
  logic [31:0] perf_q;

  // counts every edge spent outside IDLE/DONE, including the one that enters DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else if (state == IDLE || state == DONE) begin
      if (bus.ap_start) perf_q <= '0;
    end else begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_q;
`else
  assign bus.perf_cycles = '0;
`endif

  assign bus.ap_done    = ap_done_q;
  assign bus.busy       = busy_q;
  assign bus.instr_addr = instr_addr_q;
  assign bus.cur_instr  = cur_instr_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_col     = rd_col_q;
  assign bus.feed_valid = feed_valid_q;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.res_sel    = res_sel_q;
  assign bus.out_we     = out_we_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// tb/tb_sa_seq_ctrl.sv - scoreboard bench for sa_seq_ctrl (OADDR_W=7 and OADDR_W=6 instances)
module tb_sa_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] imem [8];

  always #5 clk = ~clk;

  sa_seq_ctrl_if #(.IADDR_W(3), .COL_W(8), .OADDR_W(7)) bus ();
  sa_seq_ctrl_if #(.IADDR_W(3), .COL_W(8), .OADDR_W(6)) bus6 ();

  assign bus.ap_start  = start;
  assign bus6.ap_start = start;

  always @(posedge clk) bus.instr_data  <= imem[bus.instr_addr];
  always @(posedge clk) bus6.instr_data <= imem[bus6.instr_addr];

  sa_seq_ctrl #(.OADDR_W(7)) dut  (.clk(clk), .rst(rst), .bus(bus));
  sa_seq_ctrl #(.OADDR_W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  int total = 0;
  int bad   = 0;

  logic [7:0]  col_q [$];
  logic [10:0] wr_q  [$];
  logic [9:0]  wr6_q [$];
  int   rd_cnt, we_cnt, clr_cnt, rd_rises;
  logic prev_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({bus.ap_done, bus.busy, bus.rd_en, bus.feed_valid,
                            bus.acc_clr, bus.out_we, bus.ovf}), 32'd0);
    chk({tag, "_addr"}, 32'({bus.instr_addr, bus.rd_col, bus.res_sel,
                             bus.out_addr, bus.cur_instr}), 32'd0);
    chk({tag, "_perf"}, bus.perf_cycles, 32'd0);
  endtask

  task automatic load(input logic [31:0] word);
    logic [31:0] w;
    w = word;
    for (int i = 0; i < 8; i++) imem[i] = w[4*i +: 4];
  endtask

  // reference model: pushes expected columns and writes, returns run summary
  task automatic model(output int cyc, output bit o7, output bit o6, output int nrd,
                       output int nwr, output int njobs, output logic [3:0] last);
    int base, oa, k;
    base = 0; oa = 0; cyc = 0; o7 = 0; o6 = 0; nrd = 0; nwr = 0; njobs = 0;
    last = 4'd0;
    for (int pc = 0; pc < 8; pc++) begin
      k = int'(imem[pc]);
      if (k == 0) begin
        cyc += 2;
        last = 4'd0;
        break;
      end
      last = 4'(k);
      njobs++;
      cyc += k + 29;
      for (int t = 0; t < k + 3; t++) begin
        col_q.push_back(8'(base + t));
        nrd++;
      end
      for (int s = 0; s < 16; s++) begin
        if (oa <= 127) begin
          wr_q.push_back({7'(oa), 4'(s)});
          nwr++;
        end else o7 = 1;
        if (oa <= 63) wr6_q.push_back({6'(oa), 4'(s)});
        else o6 = 1;
        oa++;
      end
      base += k + 3;
    end
  endtask

  task automatic sample();
    logic [7:0]  c;
    logic [10:0] w;
    logic [9:0]  w6;
    chk("feed_valid_trail", 32'(bus.feed_valid), 32'(prev_rd));
    if (bus.rd_en && !prev_rd) rd_rises++;
    prev_rd = bus.rd_en;
    if (bus.acc_clr) clr_cnt++;
    if (bus.rd_en) begin
      rd_cnt++;
      chk("rd_col_expected", 32'(col_q.size() > 0), 32'd1);
      if (col_q.size() > 0) begin
        c = col_q.pop_front();
        chk("rd_col", 32'(bus.rd_col), 32'(c));
      end
    end
    if (bus.out_we) begin
      we_cnt++;
      chk("wr_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        chk("wr_addr_sel", 32'({bus.out_addr, bus.res_sel}), 32'(w));
      end
    end
    if (bus6.out_we) begin
      chk("wr6_expected", 32'(wr6_q.size() > 0), 32'd1);
      if (wr6_q.size() > 0) begin
        w6 = wr6_q.pop_front();
        chk("wr6_addr_sel", 32'({bus6.out_addr, bus6.res_sel}), 32'(w6));
      end
    end
  endtask

  task automatic run(input string nm, input bit disturb, input bit abort);
    int cyc, nrd, nwr, njobs, n;
    bit o7, o6;
    logic [3:0] last;
    model(cyc, o7, o6, nrd, nwr, njobs, last);
    rd_cnt = 0; we_cnt = 0; clr_cnt = 0; rd_rises = 0;
    prev_rd = bus.rd_en;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = disturb && bus.feed_valid && !bus.rd_en;
      if (n == 1) chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
      sample();
      if (abort && bus.rd_en && rd_rises == 2) begin
        #2 rst = 1'b1;
        #1;
        chk_zero({nm, "_abort"});
        col_q.delete(); wr_q.delete(); wr6_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prev_rd = 1'b0;
        return;
      end
      if (bus.ap_done) break;
    end
    start = 1'b0;
    chk({nm, "_done_cycles"}, 32'(n), 32'(cyc));
    chk({nm, "_ap_done"}, 32'({bus.ap_done, bus.busy, bus6.ap_done}), 32'b101);
    chk({nm, "_ovf"}, 32'(bus.ovf), 32'(o7));
    chk({nm, "_ovf6"}, 32'(bus6.ovf), 32'(o6));
    chk({nm, "_cur_instr"}, 32'(bus.cur_instr), 32'(last));
    chk({nm, "_rd_pulses"}, 32'(rd_cnt), 32'(nrd));
    chk({nm, "_we_pulses"}, 32'(we_cnt), 32'(nwr));
    chk({nm, "_clr_pulses"}, 32'(clr_cnt), 32'(njobs));
    chk({nm, "_leftover"}, 32'(col_q.size() + wr_q.size() + wr6_q.size()), 32'd0);
`ifdef SA_SEQ_PERF_EN
    chk({nm, "_perf"}, bus.perf_cycles, 32'(cyc));
`else
    chk({nm, "_perf"}, bus.perf_cycles, 32'd0);
`endif
    col_q.delete(); wr_q.delete(); wr6_q.delete();
  endtask

  initial begin
    load(32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    load(32'h0003_2145);
    run("prog5", 1'b0, 1'b0);
    run("prog5_start_in_drain", 1'b1, 1'b0);

    load(32'h0);
    run("prog0", 1'b0, 1'b0);

    load(32'hFFFF_FFFF);
    run("k15x8", 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("ovf6_sticky", 32'(bus6.ovf), 32'd1);

    load(32'h0);
    run("ovf_cleared", 1'b0, 1'b0);

    load(32'h0003_2145);
    run("abort", 1'b0, 1'b1);
    run("after_abort", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
